motor_duty_ramp: RTL

//  Converts the signed PID motor command into the unsigned duty word (R+1 bits) plus direction bit

---
 rtl/motor_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/motor_duty_ramp.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared motor-control types and helpers used by the duty ramp, pwm and PID blocks.
package motor_pkg;

  typedef enum logic [1:0] {
    RAMP_OFF,
    RAMP_TRACK,
    RAMP_DECEL,
    RAMP_DEAD
  } ramp_state_t;

  // Full-scale duty (100%) for a pwm of resolution r bits.
  function automatic int duty_full(input int r);
    return 1 << r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 125000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/motor_duty_ramp.sv
// Per-wheel duty ramp: saturates the signed PID command, slew-limits the pwm duty per tick and
// forces ramp-to-zero plus dead time before the H-bridge direction may reverse.
module motor_duty_ramp
  import motor_pkg::*;
#(
  parameter int R              = 16,
  parameter int CMD_W          = 18,
  parameter int STEP           = 4096,
  parameter int TICK_DIV       = 125000,
  parameter int DEADTIME_TICKS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cmd_valid,
  input  logic signed [CMD_W-1:0] cmd,
  output logic        [R:0]       duty,
  output logic                    dir,
  output logic                    at_target
);

  localparam int FULL = duty_full(R);
  localparam logic [R:0] FULL_V = (R+1)'(FULL);
  localparam logic [R:0] STEP_V = (R+1)'((STEP > FULL) ? FULL : STEP);
  localparam int AW = (CMD_W > R) ? CMD_W + 1 : R + 1;
  localparam int DW = $clog2(DEADTIME_TICKS + 1);
  localparam logic [DW-1:0] DEAD_V = DW'(DEADTIME_TICKS);

  ramp_state_t   state_q, state_d;
  logic [R:0]    duty_q, duty_d;
  logic          dir_q, dir_d;
  logic          at_target_q, at_target_d;
  logic [R:0]    tgt_mag_q, tgt_mag_d;
  logic          tgt_dir_q, tgt_dir_d;
  logic [DW-1:0] dead_q, dead_d;

  logic          tick;
  logic [CMD_W:0] cmd_ext;
  logic [AW-1:0] cmd_abs;
  logic [R+1:0]  up_sum;
  logic [R:0]    duty_toward;
  logic [R:0]    duty_decel;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Candidate duty values; the up step is clamped at the target so it can never overshoot 2**R.
  always_comb begin
    up_sum      = {1'b0, duty_q} + {1'b0, STEP_V};
    duty_toward = duty_q;
    if (duty_q < tgt_mag_q) begin
      duty_toward = (up_sum > {1'b0, tgt_mag_q}) ? tgt_mag_q : up_sum[R:0];
    end else if (duty_q > tgt_mag_q) begin
      duty_toward = ((duty_q - tgt_mag_q) > STEP_V) ? duty_q - STEP_V : tgt_mag_q;
    end
    duty_decel = (duty_q > STEP_V) ? duty_q - STEP_V : '0;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    case (state_q)
      RAMP_OFF: begin
        duty_d = '0;
        if (enable) state_d = RAMP_TRACK;
      end
      RAMP_TRACK: begin
        if (tick) begin
          if (tgt_dir_q == dir_q) begin
            duty_d = duty_toward;
          end else if (duty_q != '0) begin
            state_d = RAMP_DECEL;
          end else begin
            state_d = RAMP_DEAD;
            dead_d  = DEAD_V;
          end
        end
      end
      RAMP_DECEL: begin
        if (tgt_dir_q == dir_q) begin
          state_d = RAMP_TRACK;
        end else if (tick) begin
          duty_d = duty_decel;
          if (duty_decel == '0) begin
            state_d = RAMP_DEAD;
            dead_d  = DEAD_V;
          end
        end
      end
      RAMP_DEAD: begin
        duty_d = '0;
        if (tgt_dir_q == dir_q) begin
          state_d = RAMP_TRACK;
        end else if (tick) begin
          if (dead_q <= DW'(1)) begin
            dead_d  = '0;
            dir_d   = tgt_dir_q;
            state_d = RAMP_TRACK;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
      end
      default: state_d = RAMP_OFF;
    endcase
    if (!enable) begin
      state_d = RAMP_OFF;
      duty_d  = '0;
    end
  end

  // A zero command follows the direction the bridge will have next cycle, so it never asks to reverse.
  always_comb begin
    tgt_mag_d = tgt_mag_q;
    tgt_dir_d = tgt_dir_q;
    cmd_ext   = {cmd[CMD_W-1], cmd};
    cmd_abs   = AW'(cmd[CMD_W-1] ? -cmd_ext : cmd_ext);
    if (cmd_valid) begin
      tgt_mag_d = (cmd_abs > AW'(FULL)) ? FULL_V : cmd_abs[R:0];
      tgt_dir_d = (tgt_mag_d == '0) ? dir_d : cmd[CMD_W-1];
    end
    at_target_d = (state_d == RAMP_TRACK) && (duty_d == tgt_mag_d) && (dir_d == tgt_dir_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RAMP_OFF;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      at_target_q <= 1'b0;
      tgt_mag_q   <= '0;
      tgt_dir_q   <= 1'b0;
      dead_q      <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      at_target_q <= at_target_d;
      tgt_mag_q   <= tgt_mag_d;
      tgt_dir_q   <= tgt_dir_d;
      dead_q      <= dead_d;
    end
  end

  assign duty      = duty_q;
  assign dir       = dir_q;
  assign at_target = at_target_q;

endmodule
